// File: rtl/recency_pkg.sv
// recency_pkg: shared types and helpers for the recency-list snapshot serializer.
// The header-beat state only exists when RECENCY_SNAP_HDR_EN is defined.
package recency_pkg;

`ifdef RECENCY_SNAP_HDR_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } snap_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } snap_state_e;
`endif

  // Width of the saturating dropped-request counter.
  localparam int DROP_W = 8;

  // Index width for a list of 'entries' slots; never narrower than one bit.
  function automatic int idx_width(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  // Population count of a (zero-extended) valid mask.
  function automatic int count_ones(input logic [63:0] mask);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n += int'(mask[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/recency_next_idx.sv
// recency_next_idx: priority encoder that finds the next valid entry index.
// With incl_cur_i set the search starts at cur_idx_i itself, otherwise just above it.
// last_o flags that no valid entry exists above the index found.
module recency_next_idx
  import recency_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = 2
) (
  input  logic [ENTRIES-1:0] valid_mask_i,
  input  logic [IDX_W-1:0]   cur_idx_i,
  input  logic               incl_cur_i,
  output logic [IDX_W-1:0]   nxt_idx_o,
  output logic               found_o,
  output logic               last_o
);

  // Scan downward so the lowest qualifying index wins, then test for anything above it.
  always_comb begin
    nxt_idx_o = '0;
    found_o   = 1'b0;
    last_o    = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_mask_i[i] &&
          ((i > int'(cur_idx_i)) || (incl_cur_i && (i == int'(cur_idx_i))))) begin
        nxt_idx_o = IDX_W'(i);
        found_o   = 1'b1;
      end
    end
    if (found_o) begin
      last_o = 1'b1;
      for (int i = 0; i < ENTRIES; i++) begin
        if (valid_mask_i[i] && (i > int'(nxt_idx_o))) begin
          last_o = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/recency_snapshot_ser.sv
// recency_snapshot_ser: captures the recency tracker's entries on request and
// streams the valid ones, most recent first, as registered valid/ready beats.
// Define RECENCY_SNAP_HDR_EN to prepend a header beat carrying the valid count.
module recency_snapshot_ser
  import recency_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ENTRIES = 4,
  localparam int IDX_W  = idx_width(ENTRIES)
) (
  input  logic                      clk_in,
  input  logic                      reset_n_in,
  input  logic [ENTRIES*DATA_W-1:0] entry_data_in,
  input  logic [ENTRIES-1:0]        entry_valid_in,
  input  logic                      snap_req_in,
  output logic                      snap_busy_out,
  output logic                      snap_done_out,
  output logic [DATA_W-1:0]         out_data,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DROP_W-1:0]         req_drop_cnt_out
);

`ifdef RECENCY_SNAP_HDR_EN
  if (DATA_W < $clog2(ENTRIES + 1)) begin : g_hdr_width_chk
    $error("DATA_W is too narrow to carry the valid-entry count in the header beat");
  end
`endif

  snap_state_e               state_q, state_d;
  logic [ENTRIES*DATA_W-1:0] shd_data_q, shd_data_d;
  logic [ENTRIES-1:0]        shd_vld_q, shd_vld_d;
  logic [DATA_W-1:0]         out_data_q, out_data_d;
  logic [IDX_W-1:0]          out_idx_q, out_idx_d;
  logic                      out_last_q, out_last_d;
  logic                      out_valid_q, out_valid_d;
  logic                      busy_q, done_q;
  logic [DROP_W-1:0]         drop_q, drop_d;

  logic [ENTRIES-1:0]        enc_mask;
  logic [IDX_W-1:0]          enc_cur;
  logic                      enc_incl;
  logic [IDX_W-1:0]          enc_idx;
  logic                      enc_found;
  logic                      enc_last;
  logic [ENTRIES*DATA_W-1:0] src_data;
  logic [DATA_W-1:0]         enc_data;

  // In IDLE the first beat is looked up in the live inputs, since the shadow
  // registers only take the captured values at the same edge.
  always_comb begin
    enc_mask = shd_vld_q;
    enc_cur  = out_idx_q;
    enc_incl = 1'b0;
    src_data = shd_data_q;
    if (state_q == ST_IDLE) begin
      enc_mask = entry_valid_in;
      enc_cur  = '0;
      enc_incl = 1'b1;
      src_data = entry_data_in;
    end
`ifdef RECENCY_SNAP_HDR_EN
    else if (state_q == ST_HDR) begin
      enc_cur  = '0;
      enc_incl = 1'b1;
    end
`endif
  end

  assign enc_data = src_data[int'(enc_idx) * DATA_W +: DATA_W];

  recency_next_idx #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_next_idx (
    .valid_mask_i (enc_mask),
    .cur_idx_i    (enc_cur),
    .incl_cur_i   (enc_incl),
    .nxt_idx_o    (enc_idx),
    .found_o      (enc_found),
    .last_o       (enc_last)
  );

`ifdef RECENCY_SNAP_HDR_EN
  int vld_cnt;
  assign vld_cnt = count_ones({{(64 - ENTRIES){1'b0}}, entry_valid_in});
`endif

  // Next-state and next-beat logic; output registers only move on capture or handshake.
  always_comb begin
    state_d     = state_q;
    shd_data_d  = shd_data_q;
    shd_vld_d   = shd_vld_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (snap_req_in) begin
          shd_data_d = entry_data_in;
          shd_vld_d  = entry_valid_in;
`ifdef RECENCY_SNAP_HDR_EN
          state_d     = ST_HDR;
          out_valid_d = 1'b1;
          out_data_d  = DATA_W'(vld_cnt);
          out_idx_d   = '0;
          out_last_d  = (vld_cnt == 0);
`else
          if (enc_found) begin
            state_d     = ST_SEND;
            out_valid_d = 1'b1;
            out_data_d  = enc_data;
            out_idx_d   = enc_idx;
            out_last_d  = enc_last;
          end else begin
            state_d = ST_DONE;
          end
`endif
        end
      end
`ifdef RECENCY_SNAP_HDR_EN
      ST_HDR: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b0;
          end else begin
            state_d    = ST_SEND;
            out_data_d = enc_data;
            out_idx_d  = enc_idx;
            out_last_d = enc_last;
          end
        end
      end
`endif
      ST_SEND: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b0;
          end else begin
            out_data_d = enc_data;
            out_idx_d  = enc_idx;
            out_last_d = enc_last;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Requests arriving outside IDLE are counted, saturating at all-ones.
  always_comb begin
    drop_d = drop_q;
    if (snap_req_in && (state_q != ST_IDLE) && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end

  // Control registers: FSM, registered busy/done flags and drop counter.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      drop_q      <= drop_d;
    end
  end

  // Data registers: shadow copy of the list and the presented beat.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      shd_data_q <= '0;
      shd_vld_q  <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      shd_data_q <= shd_data_d;
      shd_vld_q  <= shd_vld_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      out_last_q <= out_last_d;
    end
  end

  assign snap_busy_out    = busy_q;
  assign snap_done_out    = done_q;
  assign out_data         = out_data_q;
  assign out_idx          = out_idx_q;
  assign out_last         = out_last_q;
  assign out_valid        = out_valid_q;
  assign req_drop_cnt_out = drop_q;

endmodule

// File: tb/tb_recency_snapshot_ser.sv
// tb_recency_snapshot_ser: randomized and directed stimulus for recency_snapshot_ser,
// checked every cycle against a queue-based model of the snapshot stream.
module tb_recency_snapshot_ser;

`ifdef RECENCY_SNAP_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n_in;
  logic [31:0] entry_data_in;
  logic [3:0]  entry_valid_in;
  logic        snap_req_in;
  logic        snap_busy_out;
  logic        snap_done_out;
  logic [7:0]  out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  req_drop_cnt_out;

  recency_snapshot_ser #(
    .DATA_W  (8),
    .ENTRIES (4)
  ) dut (
    .clk_in           (clk),
    .reset_n_in       (reset_n_in),
    .entry_data_in    (entry_data_in),
    .entry_valid_in   (entry_valid_in),
    .snap_req_in      (snap_req_in),
    .snap_busy_out    (snap_busy_out),
    .snap_done_out    (snap_done_out),
    .out_data         (out_data),
    .out_idx          (out_idx),
    .out_last         (out_last),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .req_drop_cnt_out (req_drop_cnt_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a snapshot is the list of beats still to be accepted.
  // Phase 0 = idle, 1 = streaming, 2 = the one-cycle completion.
  typedef struct packed {
    logic [7:0] d;
    logic [1:0] i;
    logic       l;
  } beat_t;

  beat_t mq[$];
  beat_t log_q[$];
  int    m_phase = 0;
  int    m_drop  = 0;

  // Advance the model on each edge with the inputs the DUT saw, then compare.
  always @(posedge clk) begin
    beat_t b;
    if (!reset_n_in) begin
      mq.delete();
      m_phase = 0;
      m_drop  = 0;
    end else begin
      if (snap_req_in && (m_phase != 0) && (m_drop < 255)) m_drop++;
      case (m_phase)
        0: if (snap_req_in) begin
          mq.delete();
          for (int i = 0; i < 4; i++) begin
            if (entry_valid_in[i]) begin
              b.d = entry_data_in[i*8 +: 8];
              b.i = 2'(i);
              b.l = 1'b0;
              mq.push_back(b);
            end
          end
          if (mq.size() > 0) begin
            b = mq[mq.size()-1];
            b.l = 1'b1;
            mq[mq.size()-1] = b;
          end
          if (HDR != 0) begin
            b.d = 8'(mq.size());
            b.i = 2'd0;
            b.l = (mq.size() == 0);
            mq.push_front(b);
          end
          m_phase = (mq.size() == 0) ? 2 : 1;
        end
        1: if (out_ready) begin
          log_q.push_back(mq.pop_front());
          if (mq.size() == 0) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
    #1;
    chk("out_valid", out_valid, (m_phase == 1));
    chk("busy", snap_busy_out, (m_phase != 0));
    chk("done", snap_done_out, (m_phase == 2));
    chk("drop_cnt", req_drop_cnt_out, m_drop);
    if (m_phase == 1) begin
      chk("out_data", out_data, mq[0].d);
      chk("out_idx", out_idx, mq[0].i);
      chk("out_last", out_last, mq[0].l);
    end
  end

  // Drain until the model is idle; ready mode 0 = always, 1 = 1,0,0 pattern, else random.
  task automatic wait_idle(input int mode, input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((k % 3) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      entry_data_in  = $urandom;
      entry_valid_in = 4'($urandom);
      k++;
    end while ((m_phase != 0) && (k < budget));
    if (m_phase != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: still busy after %0d cycles", budget);
    end
    out_ready = 1'b1;
  endtask

  task automatic request(input logic [31:0] data, input logic [3:0] vld);
    @(negedge clk);
    entry_data_in  = data;
    entry_valid_in = vld;
    snap_req_in    = 1'b1;
    @(negedge clk);
    snap_req_in    = 1'b0;
    entry_data_in  = $urandom;
    entry_valid_in = 4'($urandom);
  endtask

  initial begin
    bit found;
    reset_n_in     = 1'b0;
    entry_data_in  = '0;
    entry_valid_in = '0;
    snap_req_in    = 1'b0;
    out_ready      = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", snap_busy_out, 0);
    chk("rst_done", snap_done_out, 0);
    chk("rst_drop", req_drop_cnt_out, 0);
    chk("rst_data", out_data, 0);
    reset_n_in = 1'b1;

    // Full list; inputs scramble while the stream drains.
    log_q.delete();
    request(32'h44332211, 4'hF);
    wait_idle(0, 40);
    chk("full_beats", log_q.size(), 4 + HDR);
    if (HDR != 0) chk("full_hdr", log_q[0].d, 8'h04);
    for (int k = 0; k < 4; k++) begin
      chk("full_data", log_q[HDR+k].d, 8'h11 * (k + 1));
      chk("full_idx", log_q[HDR+k].i, k);
      chk("full_last", log_q[HDR+k].l, (k == 3));
    end

    // Sparse valid pattern.
    log_q.delete();
    request(32'h55C066A0, 4'b0101);
    wait_idle(0, 40);
    chk("sparse_beats", log_q.size(), 2 + HDR);
    chk("sparse_d0", {log_q[HDR].d, log_q[HDR].i, log_q[HDR].l}, {8'hA0, 2'd0, 1'b0});
    chk("sparse_d1", {log_q[HDR+1].d, log_q[HDR+1].i, log_q[HDR+1].l}, {8'hC0, 2'd2, 1'b1});

    // Backpressure with a 1,0,0 ready pattern.
    log_q.delete();
    request(32'hA4A3A2A1, 4'hF);
    wait_idle(1, 60);
    chk("bp_beats", log_q.size(), 4 + HDR);
    chk("bp_last", {log_q[HDR+3].d, log_q[HDR+3].l}, {8'hA4, 1'b1});

    // Busy drops: three while stalled, one in the completion cycle.
    reset_n_in = 1'b0;
    @(negedge clk);
    reset_n_in = 1'b1;
    out_ready  = 1'b0;
    @(negedge clk);
    entry_data_in  = 32'h01020304;
    entry_valid_in = 4'hF;
    snap_req_in    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      snap_req_in = 1'b0;
      @(negedge clk);
      snap_req_in = 1'b1;
    end
    @(negedge clk);
    snap_req_in = 1'b0;
    out_ready   = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (m_phase == 2) found = 1'b1;
    end
    if (!found) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_wait: completion cycle not reached");
    end
    snap_req_in = 1'b1;
    @(negedge clk);
    snap_req_in = 1'b0;
    chk("drop_four", req_drop_cnt_out, 4);

    // Level request held through a long stall saturates the counter.
    out_ready      = 1'b0;
    entry_valid_in = 4'hF;
    snap_req_in    = 1'b1;
    repeat (300) @(negedge clk);
    chk("drop_sat", req_drop_cnt_out, 255);
    snap_req_in = 1'b0;
    wait_idle(0, 40);

    // Empty snapshot.
    @(negedge clk);
    entry_valid_in = 4'h0;
    snap_req_in    = 1'b1;
    @(negedge clk);
    snap_req_in    = 1'b0;
`ifdef RECENCY_SNAP_HDR_EN
    chk("empty_hdr_valid", out_valid, 1);
    chk("empty_hdr_data", out_data, 0);
    chk("empty_hdr_last", out_last, 1);
`else
    chk("empty_done", snap_done_out, 1);
    chk("empty_valid", out_valid, 0);
`endif
    wait_idle(0, 20);

    // Reset in the middle of the stream, with a dropped request already counted.
    @(negedge clk);
    entry_data_in  = 32'h88776655;
    entry_valid_in = 4'hF;
    snap_req_in    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    snap_req_in = 1'b0;
    reset_n_in  = 1'b0;
    @(negedge clk);
    reset_n_in  = 1'b1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", snap_busy_out, 0);
    chk("mid_rst_drop", req_drop_cnt_out, 0);
    chk("mid_rst_done", snap_done_out, 0);
    repeat (3) @(negedge clk);
    log_q.delete();
    request(32'h0D0C0B0A, 4'b1110);
    wait_idle(0, 40);
    chk("fresh_beats", log_q.size(), 3 + HDR);
    chk("fresh_first", {log_q[HDR].d, log_q[HDR].i}, {8'h0B, 2'd1});

    // Random traffic, including occasional resets.
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      entry_data_in  = $urandom;
      entry_valid_in = 4'($urandom);
      snap_req_in    = ($urandom_range(0, 7) == 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      reset_n_in     = ($urandom_range(0, 299) != 0);
    end
    reset_n_in  = 1'b1;
    snap_req_in = 1'b0;
    wait_idle(0, 40);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
